me_sa2_row_rd_ctrl: RTL and testbench

//  Read sequencer for sub-area 2 of the DMT reference window. On start it walks
//  sub_area2_row_count from ROW_START to ROW_END and issues one reference-row read
//  per row. Each read carries a bank select rdR_sel and an in-bank address rd_addr.

---
 rtl/me_sa2_row_rd_ctrl.sv | 106 ++++++++++
 tb/tb_me_sa2_row_rd_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_sa2_row_rd_ctrl.sv
// Sub-area 2 reference-row read sequencer: LOAD, then one read per accepted RUN beat, then a DONE pulse.
// Outputs registered; first read one cycle after LOAD; rd_ready low holds the current read unchanged.
module me_sa2_row_rd_ctrl #(
    parameter int ROW_W     = 7,
    parameter int SEL_W     = 4,
    parameter int ADDR_W    = 3,
    parameter int ROW_START = 10,
    parameter int ROW_END   = 73
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              rd_ready,
    output logic              rd_en,
    output logic [SEL_W-1:0]  rdR_sel,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ROW_W-1:0]  sub_area2_row_count,
    output logic              busy,
    output logic              done
);

    localparam logic [ROW_W-1:0] FIRST_ROW = ROW_W'(ROW_START);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROW_END);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state;

    // Banks are row-interleaved: low idx bits pick the bank, the rest is the in-bank row.
    function automatic logic [SEL_W-1:0] sel_of(input logic [ROW_W-1:0] row);
        logic [ROW_W-1:0] idx;
        idx = row - FIRST_ROW;
        return idx[SEL_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_W-1:0] row);
        logic [ROW_W-1:0] idx;
        idx = row - FIRST_ROW;
        return ADDR_W'(idx >> SEL_W);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= ST_IDLE;
            rd_en               <= 1'b0;
            rdR_sel             <= '0;
            rd_addr             <= '0;
            sub_area2_row_count <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state               <= ST_RUN;
                        rd_en               <= 1'b1;
                        sub_area2_row_count <= FIRST_ROW;
                        rdR_sel             <= sel_of(FIRST_ROW);
                        rd_addr             <= addr_of(FIRST_ROW);
                    end
                end
                ST_RUN: begin
                    // Abort beats rd_ready: the read presented this cycle is dropped.
                    if (abort) begin
                        state <= ST_IDLE;
                        rd_en <= 1'b0;
                        busy  <= 1'b0;
                    end else if (rd_ready) begin
                        if (sub_area2_row_count == LAST_ROW) begin
                            state <= ST_DONE;
                            rd_en <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            sub_area2_row_count <= sub_area2_row_count + ROW_W'(1);
                            rdR_sel             <= sel_of(sub_area2_row_count + ROW_W'(1));
                            rd_addr             <= addr_of(sub_area2_row_count + ROW_W'(1));
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_me_sa2_row_rd_ctrl.sv
// Bench for me_sa2_row_rd_ctrl: default sweep on dut, single-row sweep on dut1.
module tb_me_sa2_row_rd_ctrl;

    logic       clk;
    logic       rst;
    logic       start, abort, rd_ready;
    logic       rd_en, busy, done;
    logic [3:0] sel;
    logic [2:0] addr;
    logic [6:0] row;

    logic       start1, abort1, ready1;
    logic       rd_en1, busy1, done1;
    logic [3:0] sel1;
    logic [2:0] addr1;
    logic [6:0] row1;

    int checks = 0;
    int errors = 0;

    me_sa2_row_rd_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rd_ready(rd_ready),
        .rd_en(rd_en), .rdR_sel(sel), .rd_addr(addr), .sub_area2_row_count(row),
        .busy(busy), .done(done)
    );

    me_sa2_row_rd_ctrl #(.ROW_START(20), .ROW_END(20)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .rd_ready(ready1),
        .rd_en(rd_en1), .rdR_sel(sel1), .rd_addr(addr1), .sub_area2_row_count(row1),
        .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; start = 0; abort = 0; rd_ready = 0;
        start1 = 0; abort1 = 0; ready1 = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rd_en, sel, addr, row, busy, done} !== 17'd0) begin
            errors++;
            $display("FAIL reset_dut en=%0b sel=%0d addr=%0d row=%0d busy=%0b done=%0b required all 0",
                     rd_en, sel, addr, row, busy, done);
        end
        checks++;
        if ({rd_en1, sel1, addr1, row1, busy1, done1} !== 17'd0) begin
            errors++;
            $display("FAIL reset_dut1 en=%0b row=%0d busy=%0b done=%0b required all 0",
                     rd_en1, row1, busy1, done1);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // mode 0: ready=1, 1: random ready, 2: 5-cycle stall at row 18,
    // 3: abort at row 40, 4: stray start in RUN and in the DONE cycle.
    task automatic run_sweep(input int mode);
        int  r, acc, last_acc, stall, cyc, dcount;
        bit  fin;
        r = 10; acc = 0; last_acc = -10; stall = 0; fin = 0;
        @(negedge clk);
        start = 1; abort = 0; rd_ready = 1;
        @(negedge clk);
        start = 0;
        checks++;
        if (!(busy === 1'b1 && rd_en === 1'b0 && done === 1'b0)) begin
            errors++;
            $display("FAIL load_cycle mode=%0d busy=%0b en=%0b done=%0b required 1 0 0",
                     mode, busy, rd_en, done);
        end
        for (cyc = 0; cyc < 400 && !fin; cyc++) begin
            rd_ready = 1; start = 0;
            if (done === 1'b1) begin
                checks++;
                if (acc != 64 || r != 74 || cyc != last_acc + 1 || rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse mode=%0d accepted=%0d next_row=%0d gap=%0d en=%0b required 64 74 1 0",
                             mode, acc, r, cyc - last_acc, rd_en);
                end
                if (mode == 4) start = 1;
                fin = 1;
            end else if (rd_en === 1'b1) begin
                checks++;
                if (row !== 7'(r) || sel !== 4'((r - 10) % 16) ||
                    addr !== 3'(((r - 10) / 16) % 8) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL read_beat mode=%0d row=%0d sel=%0d addr=%0d busy=%0b required %0d %0d %0d 1",
                             mode, row, sel, addr, busy, r, (r - 10) % 16, ((r - 10) / 16) % 8);
                end
                if (mode == 1) rd_ready = 1'($urandom_range(0, 1));
                if (mode == 2 && r == 18 && stall < 5) begin
                    if (stall > 0) begin
                        checks++;
                        if (row !== 7'd18 || sel !== 4'd8 || addr !== 3'd0) begin
                            errors++;
                            $display("FAIL stall_hold row=%0d sel=%0d addr=%0d required 18 8 0",
                                     row, sel, addr);
                        end
                    end
                    rd_ready = 0;
                    stall++;
                end
                if (mode == 2 && r == 19 && stall == 5) begin
                    checks++;
                    if (sel !== 4'd9) begin
                        errors++;
                        $display("FAIL stall_resume sel=%0d required 9", sel);
                    end
                    stall++;
                end
                if (mode == 4 && r == 30) start = 1;
                if (mode == 3 && r == 40) abort = 1;
                if (rd_ready && !abort) begin
                    acc++; r++; last_acc = cyc;
                end
            end
            @(negedge clk);
            if (abort) begin
                abort = 0;
                checks++;
                if (rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                    row !== 7'd40 || sel !== 4'd14 || addr !== 3'd1) begin
                    errors++;
                    $display("FAIL abort_state en=%0b busy=%0b done=%0b row=%0d sel=%0d addr=%0d required 0 0 0 40 14 1",
                             rd_en, busy, done, row, sel, addr);
                end
                dcount = 0;
                for (int i = 0; i < 80; i++) begin
                    @(negedge clk);
                    if (done === 1'b1 || rd_en === 1'b1) dcount++;
                end
                checks++;
                if (dcount != 0 || acc != 30) begin
                    errors++;
                    $display("FAIL abort_quiet active_cycles=%0d accepted=%0d required 0 30", dcount, acc);
                end
                return;
            end
        end
        start = 0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL sweep_timeout mode=%0d accepted=%0d required done within 400 cycles", mode, acc);
        end else if (done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL after_done done=%0b busy=%0b en=%0b required 0 0 0", done, busy, rd_en);
        end
        if (mode == 4) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL start_in_done busy=%0b en=%0b done=%0b required 0 0 0", busy, rd_en, done);
            end
        end
    endtask

    task automatic test_full_sweep();
        run_sweep(0);
    endtask

    task automatic test_random_ready();
        run_sweep(1);
    endtask

    task automatic test_stall();
        run_sweep(2);
    endtask

    task automatic test_abort();
        run_sweep(3);
        run_sweep(0);
    endtask

    task automatic test_ignored_start();
        @(negedge clk);
        start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle busy=%0b en=%0b done=%0b required 0 0 0", busy, rd_en, done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle_late busy=%0b en=%0b required 0 0", busy, rd_en);
        end
        run_sweep(4);
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit hit;
        hit = 0;
        @(negedge clk);
        start = 1; rd_ready = 1;
        @(negedge clk);
        start = 0;
        for (n = 0; n < 100 && !hit; n++) begin
            @(negedge clk);
            if (rd_en === 1'b1 && row === 7'd30) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_reach_row30 row=%0d required 30 within 100 cycles", row);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rd_en, sel, addr, row, busy, done} !== 17'd0) begin
            errors++;
            $display("FAIL reset_mid_run en=%0b sel=%0d addr=%0d row=%0d busy=%0b done=%0b required all 0",
                     rd_en, sel, addr, row, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1 || rd_en === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL reset_stays_idle active_cycles=%0d required 0", n);
        end
    endtask

    task automatic test_single_row();
        @(negedge clk);
        start1 = 1; ready1 = 1;
        @(negedge clk);
        start1 = 0;
        checks++;
        if (busy1 !== 1'b1 || rd_en1 !== 1'b0) begin
            errors++;
            $display("FAIL single_load busy=%0b en=%0b required 1 0", busy1, rd_en1);
        end
        @(negedge clk);
        checks++;
        if (rd_en1 !== 1'b1 || row1 !== 7'd20 || sel1 !== 4'd0 || addr1 !== 3'd0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL single_beat en=%0b row=%0d sel=%0d addr=%0d done=%0b required 1 20 0 0 0",
                     rd_en1, row1, sel1, addr1, done1);
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b1 || rd_en1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL single_done done=%0b en=%0b busy=%0b required 1 0 0", done1, rd_en1, busy1);
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0 || rd_en1 !== 1'b0) begin
            errors++;
            $display("FAIL single_after done=%0b en=%0b required 0 0", done1, rd_en1);
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_stall();
        test_random_ready();
        test_abort();
        test_ignored_start();
        test_single_row();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
